uart_rx: RTL and testbench

//   8N1 asynchronous serial receiver. Oversamples the raw rx pin, finds each start bit,

---
 rtl/uart_rx_pkg.sv | 16 +
 rtl/uart_rx_sync_2ff.sv | 27 ++
 rtl/uart_rx.sv | 130 +++++++++++++
 tb/tb_uart_rx.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the 8N1 serial receiver:
// default line settings and FSM state encodings.
package uart_rx_pkg;

    localparam int DEF_CLK_FREQ = 50_000_000;
    localparam int DEF_BAUD     = 115_200;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_STOP    = 3'd3,
        ST_WAIT_HI = 3'd4
    } state_e;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for an asynchronous input pin.
// The reset value is a parameter so idle-high lines stay quiet.
module uart_rx_sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 receiver: finds the start bit, samples data and stop
// bits at their centres and strobes out each good byte.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLK_FREQ = DEF_CLK_FREQ,
    parameter int BAUD     = DEF_BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 4) begin : g_chk
        $error("uart_rx: CLKS_PER_BIT must be at least 4");
    end

    logic rx_s;

    uart_rx_sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          rx_valid_q, rx_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          busy_q, busy_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CW'(1);
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_byte_d   = rx_byte_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = ST_START;
            end
            ST_START: begin
                if (cnt_q == HALF) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d   = ST_DATA;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (cnt_q == FULL) begin
                    cnt_d = '0;
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == 3'd7) state_d = ST_STOP;
                    else bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            ST_STOP: begin
                // Leave at the stop-bit centre so a following start edge is caught.
                if (cnt_q == FULL) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        rx_byte_d  = shift_q;
                        rx_valid_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_WAIT_HI;
                    end
                end
            end
            ST_WAIT_HI: begin
                cnt_d = '0;
                if (rx_s) state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            rx_byte_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign rx_byte   = rx_byte_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit:
// frame table plus glitch, break, back-to-back and reset cases.
module tb_uart_rx;

    localparam int TCLK = 100;
    localparam int TBIT = 16 * TCLK;
    localparam int LAT  = 2 + 8 + 9 * 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    uart_rx #(.CLK_FREQ(1_600_000), .BAUD(100_000)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #(TCLK / 2) clk = ~clk;

    int checks = 0;
    int errors = 0;
    int vcnt = 0;
    int fcnt = 0;
    int last_lat = 0;
    longint t_fall = 0;
    logic prev_v = 1'b0;
    logic [7:0] rxq[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    // Pulse monitor: counts strobes and checks they never collide.
    always @(negedge clk) begin
        if (rx_valid) begin
            checks++;
            if (frame_err || prev_v) begin
                errors++;
                $display("FAIL pulse_rules: valid=%0b ferr=%0b prev_valid=%0b, expected lone valid",
                         rx_valid, frame_err, prev_v);
            end
            vcnt++;
            rxq.push_back(rx_byte);
            last_lat = int'(($time - t_fall) / TCLK);
        end
        if (frame_err) fcnt++;
        prev_v = rx_valid;
    end

    task automatic send(input logic [7:0] d, input logic stop, input int per);
        rx = 1'b0;
        t_fall = $time;
        #(per);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            #(per);
        end
        rx = stop;
        #(per);
        rx = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         per;
        int         exp_v;
        int         exp_f;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t vecs[6];
    int v0, f0;

    initial begin
        vecs[0] = '{8'h50, 1'b1, TBIT,      1, 0, 8'h50};
        vecs[1] = '{8'hA5, 1'b0, TBIT,      0, 1, 8'h50};
        vecs[2] = '{8'h00, 1'b1, TBIT - 32, 1, 0, 8'h00};
        vecs[3] = '{8'hFF, 1'b1, TBIT + 32, 1, 0, 8'hFF};
        vecs[4] = '{8'h3C, 1'b1, TBIT - 32, 1, 0, 8'h3C};
        vecs[5] = '{8'h81, 1'b1, TBIT + 32, 1, 0, 8'h81};

        #(3 * TCLK + 20);
        @(negedge clk);
        chk("rst_byte", int'(rx_byte), 0);
        chk("rst_valid", int'(rx_valid), 0);
        chk("rst_ferr", int'(frame_err), 0);
        chk("rst_busy", int'(busy), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #(4 * TCLK);

        for (int i = 0; i < 6; i++) begin
            v0 = vcnt; f0 = fcnt;
            @(posedge clk); #1;
            send(vecs[i].data, vecs[i].stop, vecs[i].per);
            #(2 * TBIT);
            chk($sformatf("v%0d_valid_cnt", i), vcnt - v0, vecs[i].exp_v);
            chk($sformatf("v%0d_ferr_cnt", i), fcnt - f0, vecs[i].exp_f);
            chk($sformatf("v%0d_byte", i), int'(rx_byte), int'(vecs[i].exp_byte));
            chk($sformatf("v%0d_busy", i), int'(busy), 0);
            if (vecs[i].exp_v == 1) begin
                checks++;
                if (last_lat < LAT - 1 || last_lat > LAT + 1) begin
                    errors++;
                    $display("FAIL v%0d_latency: got %0d cycles, expected %0d +-1",
                             i, last_lat, LAT);
                end
            end
        end

        // "P:12.5\n" with no idle gap between frames
        begin
            logic [7:0] msg[7];
            msg = '{8'h50, 8'h3A, 8'h31, 8'h32, 8'h2E, 8'h35, 8'h0A};
            rxq.delete();
            v0 = vcnt;
            @(posedge clk); #1;
            for (int i = 0; i < 7; i++) send(msg[i], 1'b1, TBIT);
            #(2 * TBIT);
            chk("b2b_count", vcnt - v0, 7);
            for (int i = 0; i < 7; i++)
                chk($sformatf("b2b_byte%0d", i),
                    (i < rxq.size()) ? int'(rxq[i]) : -1, int'(msg[i]));
        end

        v0 = vcnt; f0 = fcnt;
        @(posedge clk); #1;
        rx = 1'b0;
        #(4 * TCLK);
        rx = 1'b1;
        #(2 * TBIT);
        chk("glitch_valid", vcnt - v0, 0);
        chk("glitch_ferr", fcnt - f0, 0);
        chk("glitch_busy", int'(busy), 0);

        v0 = vcnt; f0 = fcnt;
        @(posedge clk); #1;
        rx = 1'b0;
        #(40 * TBIT);
        rx = 1'b1;
        #(2 * TBIT);
        chk("break_ferr", fcnt - f0, 1);
        chk("break_valid", vcnt - v0, 0);
        chk("break_busy", int'(busy), 0);
        v0 = vcnt;
        @(posedge clk); #1;
        send(8'h33, 1'b1, TBIT);
        #(2 * TBIT);
        chk("after_break_cnt", vcnt - v0, 1);
        chk("after_break_byte", int'(rx_byte), 8'h33);

        // reset lands in the middle of data bit 4 of 0xFF
        v0 = vcnt; f0 = fcnt;
        @(posedge clk); #1;
        rx = 1'b0;
        #(TBIT);
        rx = 1'b1;
        #(4 * TBIT + TBIT / 2);
        rst = 1'b1;
        #1;
        chk("midrst_busy_async", int'(busy), 0);
        @(negedge clk);
        chk("midrst_byte", int'(rx_byte), 0);
        chk("midrst_valid", int'(rx_valid), 0);
        chk("midrst_ferr", int'(frame_err), 0);
        #(3 * TCLK);
        @(posedge clk); #1;
        rst = 1'b0;
        #(2 * TBIT);
        chk("midrst_no_pulse_v", vcnt - v0, 0);
        chk("midrst_no_pulse_f", fcnt - f0, 0);
        chk("midrst_idle", int'(busy), 0);
        @(posedge clk); #1;
        send(8'h0F, 1'b1, TBIT);
        #(2 * TBIT);
        chk("midrst_next_cnt", vcnt - v0, 1);
        chk("midrst_next_byte", int'(rx_byte), 8'h0F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
